// File: rtl/sram_stage_sequencer_pkg.sv
// Shared types and constants for the SRAM ownership sequencer.
package sram_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_ERR
    } seq_state_type;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;
    localparam int VGA_CLIENT = 0;

endpackage

// File: rtl/sram_stage_sequencer_if.sv
// Sequencer handshake plus client/SRAM bus bundle; master drives the requests, slave is the sequencer.
interface sram_stage_sequencer_if #(
    parameter int NUM_STAGES = 2,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16
);
    localparam int OWN_W = $clog2(NUM_STAGES + 1);

    logic                              go;
    logic                              abort;
    logic [NUM_STAGES-1:0]             stage_mask;
    logic [(NUM_STAGES+1)*ADDR_W-1:0]  cl_addr;
    logic [(NUM_STAGES+1)*DATA_W-1:0]  cl_wdata;
    logic [NUM_STAGES:0]               cl_we_n;
    logic [NUM_STAGES-1:0]             stage_end;
    logic [NUM_STAGES-1:0]             stage_start;
    logic [ADDR_W-1:0]                 SRAM_address;
    logic [DATA_W-1:0]                 SRAM_write_data;
    logic                              SRAM_we_n;
    logic [OWN_W-1:0]                  owner;
    logic                              busy;
    logic                              done;
    logic                              timeout_err;

    modport master (
        output go, abort, stage_mask, cl_addr, cl_wdata, cl_we_n, stage_end,
        input  stage_start, SRAM_address, SRAM_write_data, SRAM_we_n,
               owner, busy, done, timeout_err
    );

    modport slave (
        input  go, abort, stage_mask, cl_addr, cl_wdata, cl_we_n, stage_end,
        output stage_start, SRAM_address, SRAM_write_data, SRAM_we_n,
               owner, busy, done, timeout_err
    );

endinterface

// File: rtl/sram_stage_sequencer_sram_client_mux.sv
// Routes the owning client's slice to the SRAM port; idle/gap forcing hands the bus to VGA with writes blocked.
module sram_client_mux
    import sram_stage_sequencer_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int OWN_W       = 2
) (
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
    input  logic [NUM_CLIENTS-1:0]        cl_we_n,
    input  logic [OWN_W-1:0]              owner,
    input  logic                          force_idle,
    output logic [ADDR_W-1:0]             SRAM_address,
    output logic [DATA_W-1:0]             SRAM_write_data,
    output logic                          SRAM_we_n
);

    logic [OWN_W-1:0] sel;

    always_comb begin
        sel = owner;
        if (force_idle || (int'(owner) >= NUM_CLIENTS)) begin
            sel = OWN_W'(VGA_CLIENT);
        end
        SRAM_address    = cl_addr[sel*ADDR_W +: ADDR_W];
        SRAM_write_data = cl_wdata[sel*DATA_W +: DATA_W];
        SRAM_we_n       = force_idle | cl_we_n[sel];
    end

endmodule

// File: rtl/sram_stage_sequencer.sv
// Runs the masked stage chain in order and hands SRAM ownership to the active stage.
//   state  | meaning
//   S_IDLE | VGA owns the bus, waiting for go
//   S_RUN  | one stage owns the bus, watchdog counting
//   S_GAP  | single no-write cycle between owners
//   S_ERR  | watchdog fired, held until go or abort
module sram_stage_sequencer
    import sram_stage_sequencer_pkg::*;
#(
    parameter int               NUM_STAGES    = 2,
    parameter int               ADDR_W        = DEF_ADDR_W,
    parameter int               DATA_W        = DEF_DATA_W,
    parameter int               TMR_W         = 26,
    parameter logic [TMR_W-1:0] STAGE_TIMEOUT = 26'd49999999
) (
    input logic                   CLOCK_50_I,
    input logic                   resetn,
    sram_stage_sequencer_if.slave bus
);

    localparam int               OWN_W   = $clog2(NUM_STAGES + 1);
    localparam logic [TMR_W-1:0] TO_LAST = STAGE_TIMEOUT - 1'b1;

    seq_state_type         state;
    logic [NUM_STAGES-1:0] mask_q;
    logic [NUM_STAGES-1:0] start_q;
    logic [OWN_W-1:0]      owner_q;
    logic [OWN_W-1:0]      cur_q;
    logic [TMR_W-1:0]      timer_q;
    logic                  done_q;
    logic                  err_q;
    logic [OWN_W-1:0]      launch_idle;
    logic [OWN_W-1:0]      launch_gap;
    logic                  end_hit;
    logic                  wd_hit;

    // Lowest set mask bit whose client number is above 'after'; 0 means none left.
    function automatic logic [OWN_W-1:0] next_client(input logic [NUM_STAGES-1:0] m,
                                                     input logic [OWN_W-1:0] after);
        logic [OWN_W-1:0] r;
        r = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (m[i] && (OWN_W'(i + 1) > after)) begin
                r = OWN_W'(i + 1);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [OWN_W-1:0] c);
        return NUM_STAGES'(1) << (c - 1'b1);
    endfunction

    assign launch_idle = next_client(bus.stage_mask, '0);
    assign launch_gap  = next_client(mask_q, cur_q);
    assign end_hit     = |(bus.stage_end & start_q);
    assign wd_hit      = (STAGE_TIMEOUT != '0) && (timer_q == TO_LAST);

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            mask_q  <= '0;
            start_q <= '0;
            owner_q <= '0;
            cur_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state   <= S_IDLE;
                start_q <= '0;
                owner_q <= '0;
                timer_q <= '0;
                err_q   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (bus.go) begin
                            mask_q <= bus.stage_mask;
                            err_q  <= 1'b0;
                            if (launch_idle != '0) begin
                                state   <= S_RUN;
                                owner_q <= launch_idle;
                                cur_q   <= launch_idle;
                                start_q <= onehot(launch_idle);
                                timer_q <= '0;
                            end else begin
                                state  <= S_IDLE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        // Completion takes priority over a watchdog hit in the same cycle.
                        if (end_hit) begin
                            state   <= S_GAP;
                            start_q <= '0;
                            owner_q <= '0;
                            timer_q <= '0;
                        end else if (wd_hit) begin
                            state   <= S_ERR;
                            err_q   <= 1'b1;
                            start_q <= '0;
                            owner_q <= '0;
                        end else if (timer_q != '1) begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (launch_gap != '0) begin
                            state   <= S_RUN;
                            owner_q <= launch_gap;
                            cur_q   <= launch_gap;
                            start_q <= onehot(launch_gap);
                            timer_q <= '0;
                        end else begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    sram_client_mux #(
        .NUM_CLIENTS (NUM_STAGES + 1),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .OWN_W       (OWN_W)
    ) u_mux (
        .cl_addr         (bus.cl_addr),
        .cl_wdata        (bus.cl_wdata),
        .cl_we_n         (bus.cl_we_n),
        .owner           (owner_q),
        .force_idle      ((state == S_GAP) || (state == S_ERR)),
        .SRAM_address    (bus.SRAM_address),
        .SRAM_write_data (bus.SRAM_write_data),
        .SRAM_we_n       (bus.SRAM_we_n)
    );

    assign bus.stage_start = start_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = (state == S_RUN) || (state == S_GAP);
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer: table of stage-chain runs plus timeout, abort and reset sequences.
module tb_sram_stage_sequencer;

    localparam int NS = 2;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TW = 26;

    localparam logic [AW-1:0] CL0_ADDR = 18'h00C00;
    localparam logic [AW-1:0] CL1_ADDR = 18'h2A000;
    localparam logic [AW-1:0] CL2_ADDR = 18'h15555;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    sram_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_stage_sequencer #(
        .NUM_STAGES    (NS),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TMR_W         (TW),
        .STAGE_TIMEOUT (26'd20)
    ) dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus)
    );

    typedef struct {
        logic [1:0] mask;
        int         len0;
        int         len1;
        int         abort_hi1;
        bit         busy_go;
    } stim_t;

    typedef struct {
        int first_owner, first_start, first_err;
        int done_cyc, done_cnt, s0, s1, gaps, err_cyc, last_busy, mux_bad;
        int end_busy, end_start, end_owner, end_err;
        int c2_addr, c2_we, gap_addr, gap_we, gap_seen;
    } res_t;

    typedef struct {
        stim_t s;
        int    exp_owner;
        int    exp_start;
        int    exp_done;
        int    exp_s0;
        int    exp_s1;
        int    exp_gaps;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issues go with s.mask, then models the stages for ncyc cycles while sampling at negedge.
    task automatic run_window(input stim_t s, input int ncyc, output res_t r);
        int hi0 = 0;
        int hi1 = 0;
        int o;
        logic exp_we;
        r = '{default: 0};
        @(negedge clk);
        bus.stage_mask = s.mask;
        bus.go         = 1'b1;
        bus.stage_end  = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            bus.go         = 1'b0;
            bus.abort      = 1'b0;
            bus.stage_mask = s.mask;
            o = int'(bus.owner);
            if (c == 1) begin
                r.first_owner = o;
                r.first_start = int'(bus.stage_start);
                r.first_err   = int'(bus.timeout_err);
            end
            if (c == 2) begin
                r.c2_addr = int'(bus.SRAM_address);
                r.c2_we   = int'(bus.SRAM_we_n);
            end
            if (bus.done) begin
                r.done_cnt++;
                if (r.done_cyc == 0) r.done_cyc = c;
            end
            if (bus.timeout_err && r.err_cyc == 0) r.err_cyc = c;
            if (bus.busy) r.last_busy = c;
            if (bus.stage_start[0]) hi0++;
            if (bus.stage_start[1]) hi1++;
            if (bus.busy && o == 0 && r.gap_seen == 0) begin
                r.gap_seen = 1;
                r.gap_addr = int'(bus.SRAM_address);
                r.gap_we   = int'(bus.SRAM_we_n);
            end
            if (bus.busy && o == 0 && bus.stage_start == '0 && bus.SRAM_we_n
                && bus.SRAM_address == CL0_ADDR) r.gaps++;
            if (o > NS) begin
                r.mux_bad++;
            end else begin
                exp_we = ((bus.busy && o == 0) || bus.timeout_err) ? 1'b1 : bus.cl_we_n[o];
                if (bus.SRAM_address != bus.cl_addr[o*AW +: AW]
                    || bus.SRAM_write_data != bus.cl_wdata[o*DW +: DW]
                    || bus.SRAM_we_n != exp_we) r.mux_bad++;
            end
            r.end_busy  = int'(bus.busy);
            r.end_start = int'(bus.stage_start);
            r.end_owner = o;
            r.end_err   = int'(bus.timeout_err);
            bus.stage_end[0] = bus.stage_start[0] && (hi0 == s.len0);
            // stage 1 also pulses a spurious end while stage 0 owns the bus
            bus.stage_end[1] = (bus.stage_start[1] && (hi1 == s.len1))
                             || (bus.stage_start[0] && !bus.stage_start[1] && hi0 == 2);
            if (s.abort_hi1 != 0 && bus.stage_start[1] && hi1 == s.abort_hi1) begin
                bus.abort      = 1'b1;
                bus.go         = 1'b1;
                bus.stage_mask = 2'b11;
            end
            if (s.busy_go && bus.stage_start[0] && hi0 == 2) begin
                bus.go         = 1'b1;
                bus.stage_mask = 2'b00;
            end
        end
        r.s0 = hi0;
        r.s1 = hi1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        vec_t  vecs [4];
        res_t  r;
        stim_t st;

        vecs[0] = '{s: '{2'b11, 10, 5, 0, 1'b0}, exp_owner: 1, exp_start: 1, exp_done: 18, exp_s0: 10, exp_s1: 5, exp_gaps: 2};
        vecs[1] = '{s: '{2'b10,  0, 5, 0, 1'b0}, exp_owner: 2, exp_start: 2, exp_done: 7,  exp_s0: 0,  exp_s1: 5, exp_gaps: 1};
        vecs[2] = '{s: '{2'b00,  0, 0, 0, 1'b0}, exp_owner: 0, exp_start: 0, exp_done: 1,  exp_s0: 0,  exp_s1: 0, exp_gaps: 0};
        vecs[3] = '{s: '{2'b01,  3, 0, 0, 1'b0}, exp_owner: 1, exp_start: 1, exp_done: 5,  exp_s0: 3,  exp_s1: 0, exp_gaps: 1};

        bus.go         = 1'b0;
        bus.abort      = 1'b0;
        bus.stage_mask = '0;
        bus.stage_end  = '0;
        bus.cl_addr    = {CL2_ADDR, CL1_ADDR, CL0_ADDR};
        bus.cl_wdata   = {16'hC222, 16'hB111, 16'hA000};
        bus.cl_we_n    = 3'b100;

        repeat (3) @(negedge clk);
        check("rst_owner", int'(bus.owner), 0);
        check("rst_start", int'(bus.stage_start), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.timeout_err), 0);
        check("rst_addr", int'(bus.SRAM_address), int'(CL0_ADDR));
        check("rst_we_n", int'(bus.SRAM_we_n), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_window(vecs[i].s, 24, r);
            check($sformatf("v%0d_first_owner", i), r.first_owner, vecs[i].exp_owner);
            check($sformatf("v%0d_first_start", i), r.first_start, vecs[i].exp_start);
            check($sformatf("v%0d_done_cyc", i), r.done_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_done_cnt", i), r.done_cnt, 1);
            check($sformatf("v%0d_s0_cycles", i), r.s0, vecs[i].exp_s0);
            check($sformatf("v%0d_s1_cycles", i), r.s1, vecs[i].exp_s1);
            check($sformatf("v%0d_gaps", i), r.gaps, vecs[i].exp_gaps);
            check($sformatf("v%0d_last_busy", i), r.last_busy, vecs[i].exp_done - 1);
            check($sformatf("v%0d_mux_bad", i), r.mux_bad, 0);
            check($sformatf("v%0d_end_owner", i), r.end_owner, 0);
            check($sformatf("v%0d_end_busy", i), r.end_busy, 0);
            if (i == 0) begin
                check("mux_c1_addr", r.c2_addr, int'(CL1_ADDR));
                check("mux_c1_we_n", r.c2_we, 0);
                check("mux_gap_addr", r.gap_addr, int'(CL0_ADDR));
                check("mux_gap_we_n", r.gap_we, 1);
            end
        end

        // stage 0 never ends: 20 run cycles, then the watchdog parks the sequencer in S_ERR
        st = '{2'b01, 0, 0, 0, 1'b0};
        run_window(st, 25, r);
        check("to_s0_cycles", r.s0, 20);
        check("to_err_cyc", r.err_cyc, 21);
        check("to_end_err", r.end_err, 1);
        check("to_end_busy", r.end_busy, 0);
        check("to_end_start", r.end_start, 0);
        check("to_end_owner", r.end_owner, 0);
        check("to_done_cnt", r.done_cnt, 0);
        check("to_mux_bad", r.mux_bad, 0);

        // go from S_ERR relaunches; end on the watchdog cycle counts as normal completion
        st = '{2'b01, 20, 0, 0, 1'b0};
        run_window(st, 25, r);
        check("relaunch_err", r.first_err, 0);
        check("relaunch_owner", r.first_owner, 1);
        check("relaunch_start", r.first_start, 1);
        check("tie_s0_cycles", r.s0, 20);
        check("tie_err_cyc", r.err_cyc, 0);
        check("tie_done_cyc", r.done_cyc, 22);
        check("tie_done_cnt", r.done_cnt, 1);

        // abort plus go three cycles into stage 1; an earlier go while busy must be ignored
        st = '{2'b11, 4, 10, 3, 1'b1};
        run_window(st, 20, r);
        check("ab_s0_cycles", r.s0, 4);
        check("ab_s1_cycles", r.s1, 3);
        check("ab_last_busy", r.last_busy, 8);
        check("ab_done_cnt", r.done_cnt, 0);
        check("ab_end_start", r.end_start, 0);
        check("ab_end_owner", r.end_owner, 0);
        check("ab_mux_bad", r.mux_bad, 0);

        // asynchronous reset in the middle of stage 0
        st = '{2'b11, 0, 0, 0, 1'b0};
        run_window(st, 3, r);
        check("pre_rst_start", r.end_start, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_start", int'(bus.stage_start), 0);
        check("arst_owner", int'(bus.owner), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_addr", int'(bus.SRAM_address), int'(CL0_ADDR));
        check("arst_we_n", int'(bus.SRAM_we_n), 0);
        bus.stage_end = '0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_start", int'(bus.stage_start), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_stage_sequencer.md
Name: sram_stage_sequencer

Overview:
Parametrised SRAM-ownership sequencer for the top level. Runs a chain of processing stages (e.g. M2 then M1) in order over a start/end level handshake, and routes the single SRAM controller port to whichever client currently owns it. Client 0 is the default owner (VGA read path). Adds per-stage stage skipping, a watchdog timeout, abort, and a forced no-write gap cycle on every ownership change.

Parameters:
NUM_STAGES, 2, number of sequenced stages; clients 1..NUM_STAGES map to stage_start/stage_end[0..NUM_STAGES-1]
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
TMR_W, 26, watchdog counter width
STAGE_TIMEOUT, 26'd49999999, cycles allowed per stage; 0 disables the watchdog

Ports:
CLOCK_50_I  in  1  clock
resetn  in  1  asynchronous, active-low reset
go  in  1  single-cycle pulse; start the sequence
abort  in  1  single-cycle pulse; cancel and return to idle
stage_mask  in  NUM_STAGES  bit k=1 means stage k runs; latched on accepted go
cl_addr  in  (NUM_STAGES+1)*ADDR_W  client addresses, client i at slice i
cl_wdata  in  (NUM_STAGES+1)*DATA_W  client write data
cl_we_n  in  NUM_STAGES+1  client write enables, active-low
stage_end  in  NUM_STAGES  level/pulse completion from each stage
stage_start  out  NUM_STAGES  level start to each stage
SRAM_address  out  ADDR_W  to SRAM controller
SRAM_write_data  out  DATA_W  to SRAM controller
SRAM_we_n  out  1  to SRAM controller
owner  out  $clog2(NUM_STAGES+1)  current owning client
busy  out  1  high outside S_IDLE/S_ERR
done  out  1  one-cycle pulse when the sequence completes
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset values: state S_IDLE, owner 0, stage_start 0, busy 0, done 0, timeout_err 0, timer 0, mask register 0.
- SRAM mux is combinational from the registered owner: outputs equal client[owner] slices. In S_GAP and S_ERR, address and data come from client 0 and SRAM_we_n is forced to 1.
- States: S_IDLE, S_RUN, S_GAP, S_ERR.
- S_IDLE, on go:
  - Latch stage_mask.
  - Select the lowest set bit k. If found, next cycle: state S_RUN, owner=k+1, stage_start[k]=1, timer=0.
  - If the mask is 0: done=1 for one cycle, remain in S_IDLE.
  - Latency is 1 cycle from go to stage_start/owner.
- S_RUN:
  - Timer increments each cycle.
  - stage_end[active] high: stage_start[active]<=0, owner<=0, timer<=0, state S_GAP.
  - stage_end of non-active stages is ignored.
- S_GAP (exactly 1 cycle):
  - Next set mask bit above the one just finished: S_RUN with that stage, same as launch.
  - No further bits: done=1 for one cycle, state S_IDLE.
- Watchdog:
  - In S_RUN with STAGE_TIMEOUT!=0, timer==STAGE_TIMEOUT-1 and no stage_end: timeout_err<=1, stage_start all 0, owner 0, state S_ERR.
  - If stage_end and timeout occur in the same cycle, stage_end wins (normal completion).
- S_ERR:
  - Holds until go or abort.
  - go: clears timeout_err and restarts exactly as from S_IDLE with the newly latched mask.
  - abort: clears timeout_err and goes to S_IDLE.
- abort (any state): stage_start all 0, owner 0, timer 0, S_IDLE next cycle, no done pulse. abort wins over a simultaneous go.
- go while busy is ignored.
- Timer is TMR_W bits and never wraps; it is compared against STAGE_TIMEOUT-1 only.
- stage_start is a level held for the whole stage (stages wait for start high, raise end, and expect start to drop).
- Reset mid-operation: all outputs return to reset values asynchronously. owner 0 gives the bus to VGA, with we_n taken from client 0.

Decomposition:
- Shared package (extend the existing top-state header/package): seq_state_type enum {S_IDLE,S_RUN,S_GAP,S_ERR}, default ADDR_W/DATA_W constants, and the VGA client index constant 0.
- Sub-module sram_client_mux (combinational slice select plus gap-forcing) is natural; the FSM, timer and next-stage priority finder stay in the top.

Test Plan:
1. NUM_STAGES=2, mask=2'b11, go. Stage 0 raises end after 10 cycles, stage 1 after 5 → start[0] high cycles 1-10, 1 gap cycle with we_n=1, start[1] high for 5 cycles, done pulses once, owner returns to 0.
2. mask=2'b10, go → stage 0 is never started; owner goes straight to 2 one cycle after go; done after stage 1 end.
3. mask=2'b00, go → done pulses 1 cycle later; no stage_start; busy stays 0.
4. STAGE_TIMEOUT=20, stage 0 never ends → at cycle 20 timeout_err=1, start[0]=0, state S_ERR. Then go → timeout_err=0 and stage 0 relaunched.
5. abort 3 cycles into stage 1, driven together with go → S_IDLE, stage_start=0, no done pulse, go ignored.
6. Mux check: client 1 drives addr=18'h2A000, we_n=0 while owner=1 → SRAM_address=18'h2A000 and SRAM_we_n=0. During the gap cycle SRAM_we_n=1 and the address equals client 0's.
